ntt_addr_seq: RTL and testbench

Address/control sequencer that drives the NTT address datapath of the RLWE processor. On a start pulse it walks every butterfly of every NTT stage, or every word of a bit-reversal pass, and emits per cycle the raw address, read-select, write-select, span (`m`) and stage/flag (`s`) words. The datapath registers all of these outputs, adds the half-span and delays the write side. The block sits directly upstream of the address datapath. It owns stage ordering, inter-stage hazard gaps and the final pipeline drain.

---
 rtl/ntt_addr_seq.sv | 203 ++++++++++++++++++++
 tb/tb_ntt_addr_seq.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_addr_seq.sv
// ntt_addr_seq: address/control sequencer for the NTT address datapath.
// Optional macro NTT_INVERSE_EN adds inv_i and descending-stage NTT runs.
module ntt_addr_seq #(
    parameter int ADDR_W       = 11,
    parameter int GAP_CYCLES   = 14,
    parameter int DRAIN_CYCLES = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [1:0]        mode_i,
`ifdef NTT_INVERSE_EN
    input  logic              inv_i,
`endif
    output logic [ADDR_W-1:0] addressin_w,
    output logic [1:0]        rdsel_w,
    output logic [2:0]        wtsel1_w,
    output logic [12:0]       m_w,
    output logic [3:0]        s_w,
    output logic              issue_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int BW = ADDR_W - 1;
    localparam int DW = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE_A,
        S_ISSUE_B,
        S_GAP,
        S_LIN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [3:0]        r_stage;
    logic [ADDR_W-1:0] r_cnt;
    logic [DW-1:0]     r_dly;
    logic              r_inv;
    logic              r_lin_s;

    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_rdsel;
    logic [2:0]        r_wtsel;
    logic [12:0]       r_m;
    logic [3:0]        r_s;
    logic              r_issue;
    logic              r_busy;
    logic              r_done;

    logic [BW-1:0]     w_b;
    logic [ADDR_W-1:0] w_bx;
    logic [ADDR_W-1:0] w_mask;
    logic [ADDR_W-1:0] w_top;
    logic [12:0]       w_m;
    logic              w_b_max;
    logic              w_cnt_max;
    logic              w_last_stage;
    logic [3:0]        w_next_stage;
    logic              w_inv_start;

`ifdef NTT_INVERSE_EN
    assign w_inv_start = inv_i;
`else
    assign w_inv_start = 1'b0;
`endif

    // Top index: insert a zero bit into b at position stage
    assign w_b    = r_cnt[BW-1:0];
    assign w_bx   = {1'b0, w_b};
    assign w_mask = (ADDR_W'(1) << r_stage) - ADDR_W'(1);
    assign w_top  = ((w_bx >> r_stage) << (r_stage + 4'd1))
                  | (w_bx & w_mask);
    assign w_m    = 13'd1 << (r_stage + 4'd1);

    assign w_b_max   = (w_b == {BW{1'b1}});
    assign w_cnt_max = &r_cnt;

    assign w_last_stage = r_inv ? (r_stage == 4'd0)
                                : (r_stage == 4'(ADDR_W - 1));
    assign w_next_stage = r_inv ? (r_stage - 4'd1) : (r_stage + 4'd1);

    assign addressin_w = r_addr;
    assign rdsel_w     = r_rdsel;
    assign wtsel1_w    = r_wtsel;
    assign m_w         = r_m;
    assign s_w         = r_s;
    assign issue_o     = r_issue;
    assign busy_o      = r_busy;
    assign done_o      = r_done;

    // Sequencer FSM with registered address/control outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_stage <= '0;
            r_cnt   <= '0;
            r_dly   <= '0;
            r_inv   <= 1'b0;
            r_lin_s <= 1'b0;
            r_addr  <= '0;
            r_rdsel <= '0;
            r_wtsel <= '0;
            r_m     <= '0;
            r_s     <= '0;
            r_issue <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    r_issue <= 1'b0;
                    r_busy  <= start_i;
                    if (start_i) begin
                        r_cnt   <= '0;
                        r_dly   <= '0;
                        r_inv   <= w_inv_start && (mode_i == 2'd0);
                        r_lin_s <= (mode_i != 2'd1);
                        if (mode_i == 2'd0) begin
                            r_stage <= w_inv_start ? 4'(ADDR_W - 1) : 4'd0;
                            r_state <= S_ISSUE_A;
                        end else begin
                            r_state <= S_LIN;
                        end
                    end
                end
                S_ISSUE_A: begin
                    r_addr  <= w_top;
                    r_rdsel <= 2'd0;
                    r_wtsel <= 3'd0;
                    r_m     <= w_m;
                    r_s     <= r_stage;
                    r_issue <= 1'b1;
                    r_state <= S_ISSUE_B;
                end
                S_ISSUE_B: begin
                    r_rdsel <= 2'd1;
                    r_issue <= 1'b1;
                    if (!w_b_max) begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_state <= S_ISSUE_A;
                    end else if (w_last_stage) begin
                        r_cnt   <= '0;
                        r_dly   <= '0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_cnt   <= '0;
                        r_dly   <= '0;
                        r_stage <= w_next_stage;
                        r_state <= S_GAP;
                    end
                end
                S_GAP: begin
                    r_issue <= 1'b0;
                    if (r_dly == DW'(GAP_CYCLES - 1)) begin
                        r_dly   <= '0;
                        r_state <= S_ISSUE_A;
                    end else begin
                        r_dly <= r_dly + 1'b1;
                    end
                end
                S_LIN: begin
                    r_addr  <= r_cnt;
                    r_rdsel <= 2'd2;
                    r_wtsel <= 3'd5;
                    r_m     <= '0;
                    r_s     <= {3'b000, r_lin_s};
                    r_issue <= 1'b1;
                    if (w_cnt_max) begin
                        r_cnt   <= '0;
                        r_dly   <= '0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    r_issue <= 1'b0;
                    if (r_dly == DW'(DRAIN_CYCLES - 1)) begin
                        r_dly   <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_dly <= r_dly + 1'b1;
                    end
                end
                S_DONE: begin
                    r_issue <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_issue <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ntt_addr_seq.sv
// tb_ntt_addr_seq: scoreboard bench for ntt_addr_seq.
// Expected issue stream comes from a stage/butterfly reference model.
module tb_ntt_addr_seq;

    localparam int AW  = 11;
    localparam int GAP = 14;
    localparam int DRN = 14;
    localparam int NB  = 1 << (AW - 1);
    localparam int NW  = 1 << AW;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          start_i = 1'b0;
    logic [1:0]    mode_i  = 2'd0;
    logic          inv_i   = 1'b0;
    logic [AW-1:0] addressin_w;
    logic [1:0]    rdsel_w;
    logic [2:0]    wtsel1_w;
    logic [12:0]   m_w;
    logic [3:0]    s_w;
    logic          issue_o;
    logic          busy_o;
    logic          done_o;

    ntt_addr_seq #(
        .ADDR_W(AW),
        .GAP_CYCLES(GAP),
        .DRAIN_CYCLES(DRN)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start_i(start_i),
        .mode_i(mode_i),
`ifdef NTT_INVERSE_EN
        .inv_i(inv_i),
`endif
        .addressin_w(addressin_w),
        .rdsel_w(rdsel_w),
        .wtsel1_w(wtsel1_w),
        .m_w(m_w),
        .s_w(s_w),
        .issue_o(issue_o),
        .busy_o(busy_o),
        .done_o(done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int rdsel;
        int wtsel;
        int m;
        int s;
        int rel;
    } exp_t;

    exp_t q[$];
    int   done_q[$];
    exp_t last = '{default: 0};

    int vectors     = 0;
    int miscompares = 0;
    int ncyc        = 0;
    int t_start     = 0;
    int starts      = 0;
    int aborts      = 0;
    int done_cnt    = 0;

    task automatic check(input string nm, input int act, input int expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                     nm, act, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int a, input int r, input int w,
                        input int m, input int s, input int rel);
        exp_t e;
        e.addr  = a;
        e.rdsel = r;
        e.wtsel = w;
        e.m     = m;
        e.s     = s;
        e.rel   = rel;
        q.push_back(e);
    endtask

    // Butterfly pairs stage by stage; top = b with a 0 inserted at bit st
    task automatic push_ntt(input bit inv);
        int rel;
        int st;
        int top;
        rel = 2;
        for (int k = 0; k < AW; k++) begin
            st = inv ? (AW - 1 - k) : k;
            for (int b = 0; b < NB; b++) begin
                top = (b / (1 << st)) * (1 << (st + 1)) + b % (1 << st);
                push(top, 0, 0, 1 << (st + 1), st, rel);
                push(top, 1, 0, 1 << (st + 1), st, rel + 1);
                rel += 2;
            end
            if (k < AW - 1) rel += GAP;
        end
    endtask

    task automatic push_lin(input int mode);
        for (int a = 0; a < NW; a++)
            push(a, 2, 5, 0, (mode == 1) ? 0 : 1, 2 + a);
    endtask

    // Monitor: pop and compare on every issue, check holds otherwise
    always @(negedge clk) begin
        int   rel;
        int   act;
        exp_t e;
        ncyc = ncyc + 1;
        rel  = ncyc - t_start;
        act  = ((starts - aborts) != done_cnt) ? 1 : 0;
        if (!rst_n) last = '{default: 0};
        check("busy", int'(busy_o), act);
        if (issue_o) begin
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL spurious_issue: issue_o=1, expected 0 (t=%0t)",
                         $time);
            end else begin
                e = q.pop_front();
                check("addr", int'(addressin_w), e.addr);
                check("rdsel", int'(rdsel_w), e.rdsel);
                check("wtsel", int'(wtsel1_w), e.wtsel);
                check("m", int'(m_w), e.m);
                check("s", int'(s_w), e.s);
                check("issue_cycle", rel, e.rel);
                last = e;
            end
        end else begin
            check("hold_addr", int'(addressin_w), last.addr);
            check("hold_rdsel", int'(rdsel_w), last.rdsel);
            check("hold_wtsel", int'(wtsel1_w), last.wtsel);
            check("hold_m", int'(m_w), last.m);
            check("hold_s", int'(s_w), last.s);
        end
        if (done_o) begin
            if (act == 0 || done_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL spurious_done: done_o=1, expected 0 (t=%0t)",
                         $time);
            end else begin
                check("done_cycle", rel, done_q.pop_front());
                done_cnt++;
            end
        end
    end

    task automatic abort();
        rst_n = 1'b0;
        #1;
        check("rst_addr", int'(addressin_w), 0);
        check("rst_rdsel", int'(rdsel_w), 0);
        check("rst_wtsel", int'(wtsel1_w), 0);
        check("rst_m", int'(m_w), 0);
        check("rst_s", int'(s_w), 0);
        check("rst_issue", int'(issue_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_done", int'(done_o), 0);
        q.delete();
        done_q.delete();
        aborts++;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic run(input int mode, input bit inv,
                       input int pulse_at, input int abort_at);
        int n;
        int lim;
        int drel;
        if (mode == 0) begin
            push_ntt(inv);
            drel = 1 + (AW * NW + (AW - 1) * GAP + DRN + 1);
        end else begin
            push_lin(mode);
            drel = 1 + (NW + DRN + 1);
        end
        done_q.push_back(drel);
        mode_i  = 2'(mode);
        inv_i   = inv;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        t_start = ncyc;
        starts++;
        n   = 0;
        lim = drel + 50;
        while ((starts - aborts) != done_cnt && n < lim) begin
            if (n == abort_at) begin
                abort();
                break;
            end
            start_i = (n == pulse_at);
            mode_i  = 2'($urandom);
            inv_i   = 1'($urandom);
            tick();
            n++;
        end
        start_i = 1'b0;
        if ((starts - aborts) != done_cnt) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: no done_o within %0d cycles", lim);
            abort();
        end
    endtask

    initial begin
        bit inv;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (50) tick();

        run(1, 1'b0, $urandom_range(10, 1500), -1);
        repeat ($urandom_range(0, 3)) tick();
        run(0, 1'b0, $urandom_range(100, 20000), -1);

        for (int i = 0; i < 3; i++) begin
            if (i != 0) repeat ($urandom_range(0, 3)) tick();
            run($urandom_range(1, 3), 1'b0, $urandom_range(5, 1800), -1);
        end

`ifdef NTT_INVERSE_EN
        inv = 1'($urandom);
`else
        inv = 1'b0;
`endif
        tick();
        run(0, inv, -1, 2 + 5 * NB * 2 + 5 * GAP + $urandom_range(0, 2000));

`ifdef NTT_INVERSE_EN
        run(0, 1'b1, -1, 2 + 2 * NB + $urandom_range(0, 20));
`endif

        run(2, 1'b0, -1, -1);
        repeat (5) tick();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
